// File: rtl/wb_mux_n_guard_pkg.sv
// wb_guard_pkg
// Shared types and sizing helpers for the guarded N-way Wishbone slave mux.
//   state_t    : FSM states of the mux (IDLE, BUSY, DERR)
//   sel_idx_w  : width of a slave index for a given slave count (at least 1 bit)
//   cnt_w      : width of the no-ack timeout counter for a given timeout length
package wb_guard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DERR = 2'd2
  } state_t;

  // SEL_IDX_W = $clog2(N_SLAVES>1 ? N_SLAVES : 2); the slave count is a module
  // parameter, so the package provides it as a function.
  function automatic int sel_idx_w(input int n_slaves);
    return $clog2((n_slaves > 1) ? n_slaves : 2);
  endfunction

  // The counter only has to reach TIMEOUT_CYCLES-1 before the abort fires.
  function automatic int cnt_w(input int timeout_cycles);
    return (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  endfunction

endpackage

// File: rtl/wb_mux_n_guard_addr_decoder.sv
// wb_addr_decoder
// Combinational address decoder for the guarded Wishbone mux.
// Compares the master address against N base/mask pairs and reports the
// lowest-index slave that matches.
// Ports:
//   adr      in   ADDR_WIDTH   master address
//   hit_any  out  1            at least one enabled slave matches
//   idx      out  IDX_W        index of the lowest matching slave (0 when no hit)
module wb_addr_decoder #(
  parameter int N_SLAVES   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = 2,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR = '0,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] adr,
  output logic                  hit_any,
  output logic [IDX_W-1:0]      idx
);

  logic [N_SLAVES-1:0] hit;

  // A slave with an all-zero mask would otherwise match every address, so a
  // zero mask is treated as "slot disabled".
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      hit[i] = (|SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
               (((adr ^ SLAVE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]) &
                 SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == '0);
    end
  end

  // Scanning downwards lets the lowest matching index overwrite the others.
  always_comb begin
    idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign hit_any = |hit;

endmodule

// File: rtl/wb_mux_n_guard.sv
// wb_mux_n_guard
// Guarded N-way Wishbone classic slave mux. Decodes the master address against
// N base/mask pairs, routes one cycle to the selected slave, answers unmapped
// addresses with a bus error, aborts slaves that never respond, and keeps a
// record of the last failing address plus a saturating error count.
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   wbm_*                       master-side Wishbone (adr/dat/we/sel/cyc/stb in,
//                               dat/ack/err/rty out)
//   wbs_*                       N packed slave-side Wishbone ports
//   timeout_o                   one-cycle pulse on a timeout abort
//   err_adr_o                   address of the latest decode error or timeout
//   err_cnt_o                   decode errors plus timeouts, saturating at 255
module wb_mux_n_guard
  import wb_guard_pkg::*;
#(
  parameter int N_SLAVES       = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR = '0,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [ADDR_WIDTH-1:0]          wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]          wbm_dat_i,
  output logic [DATA_WIDTH-1:0]          wbm_dat_o,
  input  logic                           wbm_we_i,
  input  logic [SEL_WIDTH-1:0]           wbm_sel_i,
  input  logic                           wbm_cyc_i,
  input  logic                           wbm_stb_i,
  output logic                           wbm_ack_o,
  output logic                           wbm_err_o,
  output logic                           wbm_rty_o,
  output logic [N_SLAVES*ADDR_WIDTH-1:0] wbs_adr_o,
  output logic [N_SLAVES*DATA_WIDTH-1:0] wbs_dat_o,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
  output logic [N_SLAVES-1:0]            wbs_we_o,
  output logic [N_SLAVES*SEL_WIDTH-1:0]  wbs_sel_o,
  output logic [N_SLAVES-1:0]            wbs_cyc_o,
  output logic [N_SLAVES-1:0]            wbs_stb_o,
  input  logic [N_SLAVES-1:0]            wbs_ack_i,
  input  logic [N_SLAVES-1:0]            wbs_err_i,
  input  logic [N_SLAVES-1:0]            wbs_rty_i,
  output logic                           timeout_o,
  output logic [ADDR_WIDTH-1:0]          err_adr_o,
  output logic [7:0]                     err_cnt_o
);

  localparam int SEL_IDX_W = sel_idx_w(N_SLAVES);
  localparam int CNT_W     = cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                state_q, state_d;
  logic [SEL_IDX_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] err_adr_q, err_adr_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic                  dec_hit;
  logic [SEL_IDX_W-1:0]  dec_idx;

  logic                  s_ack, s_err, s_rty;
  logic [DATA_WIDTH-1:0] s_dat;
  logic                  s_resp;
  logic                  timeout_hit;

  wb_addr_decoder #(
    .N_SLAVES   (N_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (SEL_IDX_W),
    .SLAVE_ADDR (SLAVE_ADDR),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .adr     (wbm_adr_i),
    .hit_any (dec_hit),
    .idx     (dec_idx)
  );

  // Address, data, write enable and byte selects fan out to every slot; only
  // cyc/stb decide which slave actually sees the cycle.
  assign wbs_adr_o = {N_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {N_SLAVES{wbm_dat_i}};
  assign wbs_we_o  = {N_SLAVES{wbm_we_i}};
  assign wbs_sel_o = {N_SLAVES{wbm_sel_i}};

  assign err_adr_o = err_adr_q;
  assign err_cnt_o = err_cnt_q;

  // Response lines of the latched slave. The loop compare keeps the select
  // in range even when SEL_IDX_W can encode more slots than exist.
  always_comb begin
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    s_dat = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q == SEL_IDX_W'(i)) begin
        s_ack = wbs_ack_i[i];
        s_err = wbs_err_i[i];
        s_rty = wbs_rty_i[i];
        s_dat = wbs_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign s_resp = s_ack | s_err | s_rty;

  // A response on the final counted cycle wins over the abort.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST) && !s_resp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      err_adr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      err_adr_q <= err_adr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    err_adr_d = err_adr_q;
    err_cnt_d = err_cnt_q;
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    wbm_ack_o = 1'b0;
    wbm_err_o = 1'b0;
    wbm_rty_o = 1'b0;
    wbm_dat_o = '0;
    timeout_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (dec_hit) begin
            sel_d   = dec_idx;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = DERR;
          end
        end
      end

      BUSY: begin
        if (!wbm_cyc_i) begin
          // Master abort: everything stays quiet, counter untouched.
          state_d = IDLE;
        end else if (timeout_hit) begin
          wbm_err_o = 1'b1;
          timeout_o = 1'b1;
          err_adr_d = wbm_adr_i;
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          state_d   = IDLE;
        end else begin
          for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q == SEL_IDX_W'(i)) begin
              wbs_cyc_o[i] = 1'b1;
              wbs_stb_o[i] = wbm_stb_i;
            end
          end
          wbm_ack_o = s_ack;
          wbm_err_o = s_err;
          wbm_rty_o = s_rty;
          wbm_dat_o = s_dat;
          if (s_resp) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      DERR: begin
        wbm_err_o = 1'b1;
        err_adr_d = wbm_adr_i;
        err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
